// File: rtl/wb_stage_p_pkg.sv
// Shared constants for the write-back stage: opcodes, write-mode codes,
// FSM states and datapath defaults.
package wb_stage_p_pkg;

  localparam int WB_WIDTH        = 32;
  localparam int WB_REG_ADDR_LEN = 5;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_I_TYPE = 6'h08;
  localparam logic [5:0] OP_JALR   = 6'h09;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  typedef enum logic [1:0] {
    WM_WORD = 2'd0,
    WM_HALF = 2'd1,
    WM_BYTE = 2'd2
  } wmode_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  function automatic logic is_link_op(input logic [5:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of the
// loaded word and sign- or zero-extends it to the datapath width.
module wb_load_align
  import wb_stage_p_pkg::*;
#(
  parameter int WIDTH = WB_WIDTH
) (
  input  logic [WIDTH-1:0] z_i,
  input  logic [1:0]       addr_lo_i,
  input  wmode_e           size_i,
  input  logic             ld_unsigned_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] byte_shift;
  logic [WIDTH-1:0] half_shift;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  // Halfword selection uses only addr_lo[1]; the low offset bit is ignored.
  assign byte_shift = z_i >> {addr_lo_i, 3'b000};
  assign half_shift = z_i >> {addr_lo_i[1], 4'b0000};
  assign byte_sel   = byte_shift[7:0];
  assign half_sel   = half_shift[15:0];

  always_comb begin
    data_o = z_i;
    case (size_i)
      WM_HALF: data_o = ld_unsigned_i ? {{(WIDTH-16){1'b0}}, half_sel}
                                      : {{(WIDTH-16){half_sel[15]}}, half_sel};
      WM_BYTE: data_o = ld_unsigned_i ? {{(WIDTH-8){1'b0}}, byte_sel}
                                      : {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      default: data_o = z_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_p.sv
// Write-back stage with load alignment, r0 suppression, halt/resume FSM and a
// retired-instruction counter. Optional EX bypass ports under WB_BYPASS_EN.
module wb_stage_p
  import wb_stage_p_pkg::*;
#(
  parameter int WIDTH        = WB_WIDTH,
  parameter int REG_ADDR_LEN = WB_REG_ADDR_LEN,
  parameter int LINK_REG     = 31,
  parameter int PC_W         = WIDTH - 2,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        IR_in,
  input  logic [PC_W-1:0]         PC_in,
  input  logic [WIDTH-1:0]        Z_in,
  input  logic [1:0]              addr_lo,
  input  logic                    ld_unsigned,
  input  logic                    resume,
  output logic                    Halt,
  output logic [REG_ADDR_LEN-1:0] Addr,
  output logic [WIDTH-1:0]        Data,
  output logic                    wr_en,
  output logic [1:0]              w_mode,
  output logic [PC_W-1:0]         halt_pc,
  output logic [CNT_W-1:0]        retired
`ifdef WB_BYPASS_EN
  ,
  output logic                    byp_valid,
  output logic [REG_ADDR_LEN-1:0] byp_addr,
  output logic [WIDTH-1:0]        byp_data
`endif
);

  wb_state_e               state_q;
  logic                    halt_q;
  logic [REG_ADDR_LEN-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]        data_q, data_d;
  wmode_e                  wmode_q, wmode_d;
  logic                    wr_en_q;
  logic [PC_W-1:0]         halt_pc_q;
  logic [CNT_W-1:0]        retired_q;

  logic [5:0]              op;
  logic [REG_ADDR_LEN-1:0] rd;
  logic                    is_write;
  logic                    xfer;
  logic                    unused_ir_bits;

  assign op             = IR_in[WIDTH-1 -: 6];
  assign rd             = IR_in[WIDTH-7 -: REG_ADDR_LEN];
  assign unused_ir_bits = ^IR_in[WIDTH-REG_ADDR_LEN-7:0];
  assign in_ready       = (state_q == ST_RUN);
  assign xfer           = in_valid && in_ready;

  always_comb begin
    is_write = 1'b0;
    wmode_d  = WM_WORD;
    addr_d   = rd;
    case (op)
      OP_LW, OP_R_TYPE, OP_I_TYPE: is_write = 1'b1;
      OP_LH: begin
        is_write = 1'b1;
        wmode_d  = WM_HALF;
      end
      OP_LB: begin
        is_write = 1'b1;
        wmode_d  = WM_BYTE;
      end
      OP_JAL, OP_JALR: begin
        is_write = 1'b1;
        addr_d   = REG_ADDR_LEN'(LINK_REG);
      end
      default: is_write = 1'b0;
    endcase
  end

  wb_load_align #(.WIDTH(WIDTH)) u_align (
    .z_i           (Z_in),
    .addr_lo_i     (addr_lo),
    .size_i        (wmode_d),
    .ld_unsigned_i (ld_unsigned),
    .data_o        (data_d)
  );

  // Writes to r0 still update Addr/Data; only the strobe is suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      halt_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wmode_q   <= WM_WORD;
      wr_en_q   <= 1'b0;
      halt_pc_q <= '0;
      retired_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (xfer) begin
            retired_q <= retired_q + CNT_W'(1);
            if (is_write) begin
              addr_q  <= addr_d;
              data_q  <= data_d;
              wmode_q <= wmode_d;
              wr_en_q <= (addr_d != '0);
            end else if (op == OP_HALT) begin
              halt_pc_q <= PC_in;
              state_q   <= ST_HALTED;
              halt_q    <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state_q <= ST_RUN;
            halt_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Halt    = halt_q;
  assign Addr    = addr_q;
  assign Data    = data_q;
  assign wr_en   = wr_en_q;
  assign w_mode  = wmode_q;
  assign halt_pc = halt_pc_q;
  assign retired = retired_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = xfer && is_write && (addr_d != '0);
  assign byp_addr  = addr_d;
  assign byp_data  = data_d;
`endif

endmodule

// File: doc/wb_stage_p.md
Name: wb_stage_p

Overview:
- Parametrised write-back stage; next generation of the pipeline's WB block.
- Sits after MEM. Retires one instruction per cycle over a valid/ready handshake and drives the register-file write port.
- Adds over the previous stage:
  - load-data alignment with sign/zero extension;
  - r0 write suppression;
  - a halt/resume state machine;
  - a retired-instruction counter.

Parameters:
- WIDTH, 32, datapath and instruction width.
- REG_ADDR_LEN, 5, register-file address width.
- LINK_REG, 31, destination register for JAL/JALR.
- PC_W, WIDTH-2, width of PC_in.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM holds a valid instruction.
- in_ready  out  1  WB accepts this cycle.
- IR_in  in  WIDTH  instruction; OpCode = IR_in[31:26], Rd = IR_in[25:21].
- PC_in  in  PC_W  instruction PC; debug only.
- Z_in  in  WIDTH  ALU result, link value or loaded memory word.
- addr_lo  in  2  byte offset of load address.
- ld_unsigned  in  1  zero-extend sub-word loads when 1.
- resume  in  1  leave HALTED state.
- Halt  out  1  processor halted.
- Addr  out  REG_ADDR_LEN  register-file write address.
- Data  out  WIDTH  register-file write data.
- wr_en  out  1  register-file write strobe, one cycle per write.
- w_mode  out  2  write-mode code: 0 = word, 1 = halfword, 2 = byte.
- halt_pc  out  PC_W  PC of the HALT instruction.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (async):
  - Addr, Data, w_mode, halt_pc, retired = 0.
  - wr_en = 0, Halt = 0.
  - State = RUN.
- in_ready = (state == RUN). Transfer occurs when in_valid && in_ready at a rising edge.
- Latency: transfer at edge N drives Addr/Data/wr_en/w_mode as registers from edge N; the write-enable strobe is high for exactly one cycle. Register file samples at edge N+1.
- No transfer in a cycle: wr_en = 0 next cycle. Addr and Data hold their last values.
- Decode on transfer:
  - LW: Data = Z_in, w_mode = 0.
  - LH:
    - halfword = Z_in[16*addr_lo[1] +: 16];
    - extended by sign or zero per ld_unsigned;
    - w_mode = 1;
    - addr_lo[0] is ignored.
  - LB:
    - byte = Z_in[8*addr_lo +: 8];
    - extended likewise;
    - w_mode = 2.
  - R_TYPE, I_TYPE: Data = Z_in, w_mode = 0.
  - JAL, JALR: Addr = LINK_REG, Data = Z_in, w_mode = 0.
  - All writes other than JAL/JALR use Addr = Rd.
  - HALT: no write; halt_pc = PC_in; state goes to HALTED.
  - Any other opcode (stores, branches, NOP): no write; counts as retired.
- Destination register 0: wr_en is forced to 0. Addr and Data still update. The instruction still counts as retired.
- Counter: retired increments by 1 per transfer, HALT included. It wraps modulo 2^CNT_W.
- FSM states:
  - RUN: in_ready = 1; Halt = 0.
  - HALTED:
    - in_ready = 0, Halt = 1, wr_en = 0.
    - Goes to RUN on resume = 1. Halt deasserts from the next edge.
    - resume is ignored in RUN.
- Transfer of HALT with resume = 1 in the same cycle: still enters HALTED, because resume is sampled only in HALTED. At least one halted cycle is guaranteed.
- Reset during HALTED or with a write pending: immediate return to RUN with all outputs at reset values. The pending write is dropped.
- in_valid = 0 in HALTED: no effect on state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - adds outputs byp_valid (1), byp_addr (REG_ADDR_LEN) and byp_data (WIDTH);
  - these are combinational copies of the write that will be registered this cycle;
  - byp_valid = transfer && write-enable condition, so EX can forward one cycle earlier.
- Undefined: ports absent; no combinational path from IR_in/Z_in to outputs.

Decomposition:
- Shared package/include:
  - opcode constants (LW, LH, LB, R_TYPE, I_TYPE, JAL, JALR, HALT);
  - w_mode codes WM_WORD = 0, WM_HALF = 1, WM_BYTE = 2;
  - FSM state encoding;
  - WIDTH and REG_ADDR_LEN defaults.
- One sub-module: wb_load_align (combinational); inputs Z_in, addr_lo, size, ld_unsigned; output extended Data.

Test Plan:
- Reset mid-run:
  - stimulus: assert rst while wr_en = 1;
  - response: all outputs 0, state RUN, in_ready = 1 the same cycle.
- Load byte:
  - stimulus: LB with Z_in = 0x80FF7F01, Rd = 3, addr_lo = 3, ld_unsigned = 0;
  - response: next cycle wr_en = 1, Addr = 3, Data = 0xFFFFFF80, w_mode = 2.
  - Repeat with ld_unsigned = 1; response: Data = 0x00000080.
- Load halfword:
  - stimulus: LH with Z_in = 0x8001_1234, addr_lo = 2, signed;
  - response: Data = 0xFFFF8001, w_mode = 1.
- Link and r0 writes:
  - stimulus: JAL with Z_in = 0x104;
  - response: Addr = 31, Data = 0x104.
  - stimulus: R_TYPE with Rd = 0;
  - response: wr_en = 0, retired still increments.
- Halt and resume:
  - stimulus: HALT at PC 0x40, then in_valid held high;
  - response: Halt = 1, halt_pc = 0x40, in_ready = 0, no writes.
  - stimulus: pulse resume;
  - response: RUN next edge, next instruction accepted.
- Back-to-back throughput:
  - stimulus: 8 consecutive I_TYPE transfers;
  - response: 8 wr_en pulses on consecutive cycles, retired = 8.
  - With CNT_W = 4 and 17 transfers: retired = 1.
